// File: rtl/stack_spill.sv
// Register stack whose bottom entry spills to / refills from memory; each transfer takes >=2 cycles.
// busy stalls the core while a transfer waits on mem_ack; front-end ops during busy are dropped.
module stack_spill #(
  parameter int          DEPTH = 3,
  parameter logic [15:0] BASE  = 16'h0100,
  parameter logic [15:0] LIMIT = 16'h0200
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_push,
  input  logic        i_pop,
  input  logic        i_load,
  input  logic [15:0] i_data_in,
  output logic [15:0] o_data0,
  output logic [15:0] o_data1,
  output logic        o_busy,
  output logic        o_overflow,
  output logic [15:0] o_mem_addr,
  output logic [15:0] o_mem_wdata,
  output logic        o_mem_wr,
  output logic        o_mem_rd,
  input  logic [15:0] i_mem_rdata,
  input  logic        i_mem_ack
);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, SPILL, FILL} state_t;

  state_t        r_state, w_next;
  logic [15:0]   r_e [DEPTH];
  logic [CW-1:0] r_cnt;
  logic [15:0]   r_sp;
  logic [15:0]   r_mem_addr, r_mem_wdata;
  logic          r_mem_wr, r_mem_rd, r_ovf;

  logic w_idle, w_push_op, w_pop_op, w_load_op, w_full, w_spill, w_fill;

  assign w_idle    = (r_state == IDLE);
  assign w_push_op = w_idle & i_push & ~i_pop;
  assign w_pop_op  = w_idle & i_pop & ~i_push;
  assign w_load_op = w_idle & i_load;
  assign w_full    = (r_cnt == CW'(DEPTH));
  assign w_spill   = w_push_op & w_full & (r_sp < LIMIT);
  assign w_fill    = w_pop_op & (r_sp > BASE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_spill) w_next = SPILL;
               else if (w_fill) w_next = FILL;
      SPILL:   if (i_mem_ack) w_next = IDLE;
      FILL:    if (i_mem_ack) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_e[i] <= '0;
      r_cnt       <= '0;
      r_sp        <= BASE;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wr    <= 1'b0;
      r_mem_rd    <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_push_op) begin
            for (int i = DEPTH - 1; i > 0; i--) r_e[i] <= r_e[i-1];
            r_e[0] <= i_load ? i_data_in : r_e[0];
            if (!w_full) r_cnt <= r_cnt + 1'b1;
            if (w_spill) begin
              r_mem_wdata <= r_e[DEPTH-1];
              r_mem_addr  <= r_sp;
              r_mem_wr    <= 1'b1;
            end else if (w_full) begin
              r_ovf <= 1'b1;
            end
          end else if (w_pop_op) begin
            for (int i = 0; i < DEPTH - 1; i++) r_e[i] <= r_e[i+1];
            r_e[DEPTH-1] <= '0;
            r_e[0]       <= i_load ? i_data_in : r_e[1];
            if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
            if (w_fill) begin
              r_mem_addr <= r_sp - 16'd2;
              r_mem_rd   <= 1'b1;
            end
          end else if (w_load_op) begin
            r_e[0] <= i_data_in;
          end
        end
        SPILL: if (i_mem_ack) begin
          r_sp     <= r_sp + 16'd2;
          r_mem_wr <= 1'b0;
        end
        FILL: if (i_mem_ack) begin
          // r_cnt is already the post-pop count, so it indexes the first empty slot
          r_e[r_cnt] <= i_mem_rdata;
          r_cnt      <= r_cnt + 1'b1;
          r_sp       <= r_sp - 16'd2;
          r_mem_rd   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_data0     = (r_cnt != '0)     ? r_e[0] : '0;
  assign o_data1     = (r_cnt > CW'(1))  ? r_e[1] : '0;
  assign o_busy      = ~w_idle;
  assign o_overflow  = r_ovf;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_wr    = r_mem_wr;
  assign o_mem_rd    = r_mem_rd;
endmodule

// File: tb/tb_stack_spill.sv
// Directed bench for stack_spill: spill/fill, delayed ack, overflow with a tight LIMIT, reset mid-fill.
module tb_stack_spill;
  logic        clk = 1'b0;
  logic        rst, push, pop, load, ack;
  logic [15:0] din, d0, d1, addr, wdata, rdata;
  logic        busy, ovf, wr, rd;

  logic        rst2, push2, load2;
  logic [15:0] din2, d0_2, d1_2, addr2, wdata2;
  logic        busy2, ovf2, wr2, rd2;

  logic [15:0] mem [0:255];
  int          errors = 0;
  int          checks = 0;
  logic        wr_seen;

  always #5 clk = ~clk;

  stack_spill dut (
    .i_clk(clk), .i_rst(rst), .i_push(push), .i_pop(pop), .i_load(load), .i_data_in(din),
    .o_data0(d0), .o_data1(d1), .o_busy(busy), .o_overflow(ovf),
    .o_mem_addr(addr), .o_mem_wdata(wdata), .o_mem_wr(wr), .o_mem_rd(rd),
    .i_mem_rdata(rdata), .i_mem_ack(ack)
  );

  stack_spill #(.DEPTH(3), .BASE(16'h0100), .LIMIT(16'h0102)) dut2 (
    .i_clk(clk), .i_rst(rst2), .i_push(push2), .i_pop(1'b0), .i_load(load2), .i_data_in(din2),
    .o_data0(d0_2), .o_data1(d1_2), .o_busy(busy2), .o_overflow(ovf2),
    .o_mem_addr(addr2), .o_mem_wdata(wdata2), .o_mem_wr(wr2), .o_mem_rd(rd2),
    .i_mem_rdata(16'h0000), .i_mem_ack(1'b1)
  );

  assign rdata = mem[addr[8:1]];

  always @(posedge clk) if (wr && ack) mem[addr[8:1]] <= wdata;

  always @(negedge clk) begin
    if (wr) wr_seen = 1'b1;
    checks++;
    assert (!(wr && rd)) else begin
      errors++;
      $error("FAIL wr_rd_exclusive observed wr=%0b rd=%0b required not both", wr, rd);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic p, input logic q, input logic l, input logic [15:0] d);
    push = p; pop = q; load = l; din = d;
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0; load = 1'b0;
  endtask

  task automatic op2(input logic [15:0] d);
    push2 = 1'b1; load2 = 1'b1; din2 = d;
    @(posedge clk); #1;
    push2 = 1'b0; load2 = 1'b0;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    rst = 1'b1; rst2 = 1'b1; push = 0; pop = 0; load = 0; din = 0; ack = 1'b1;
    push2 = 0; load2 = 0; din2 = 0; wr_seen = 1'b0;
    #1;
    chk("rst_data0", 32'(d0), 32'h0);
    chk("rst_data1", 32'(d1), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ovf", 32'(ovf), 32'h0);
    chk("rst_wr", 32'(wr), 32'h0);
    chk("rst_rd", 32'(rd), 32'h0);
    chk("rst_addr", 32'(addr), 32'h0);
    chk("rst_wdata", 32'(wdata), 32'h0);
    tick; tick;
    rst = 1'b0; rst2 = 1'b0;

    // 1: fill the register file without touching memory
    wr_seen = 1'b0;
    op(1, 0, 1, 16'd1); op(1, 0, 1, 16'd2); op(1, 0, 1, 16'd3);
    chk("t1_data0", 32'(d0), 32'd3);
    chk("t1_data1", 32'(d1), 32'd2);
    chk("t1_busy", 32'(busy), 32'h0);
    chk("t1_no_wr", 32'(wr_seen), 32'h0);

    // 2: fourth push spills the bottom entry
    op(1, 0, 1, 16'd4);
    chk("t2_wr", 32'(wr), 32'h1);
    chk("t2_addr", 32'(addr), 32'h0100);
    chk("t2_wdata", 32'(wdata), 32'h0001);
    chk("t2_busy", 32'(busy), 32'h1);
    tick;
    chk("t2_busy_done", 32'(busy), 32'h0);
    chk("t2_wr_done", 32'(wr), 32'h0);
    chk("t2_data0", 32'(d0), 32'd4);
    chk("t2_data1", 32'(d1), 32'd3);
    chk("t2_mem", 32'(mem[8'h80]), 32'h0001);

    // 3: pop triggers a refill from 0x0100
    op(0, 1, 0, 16'd0);
    chk("t3_data0", 32'(d0), 32'd3);
    chk("t3_data1", 32'(d1), 32'd2);
    chk("t3_rd", 32'(rd), 32'h1);
    chk("t3_addr", 32'(addr), 32'h0100);
    chk("t3_busy", 32'(busy), 32'h1);
    tick;
    chk("t3_rd_done", 32'(rd), 32'h0);
    chk("t3_busy_done", 32'(busy), 32'h0);
    chk("t3_pop1_top", 32'(d0), 32'd3);
    op(0, 1, 0, 16'd0);
    chk("t3_pop1_busy", 32'(busy), 32'h0);
    chk("t3_pop2_top", 32'(d0), 32'd2);
    op(0, 1, 0, 16'd0);
    chk("t3_pop3_top", 32'(d0), 32'd1);
    op(0, 1, 0, 16'd0);
    chk("t3_empty_d0", 32'(d0), 32'd0);
    chk("t3_empty_busy", 32'(busy), 32'h0);

    // 4: spill with mem_ack held off for 3 cycles; push during busy is dropped
    op(1, 0, 1, 16'd7); op(1, 0, 1, 16'd8); op(1, 0, 1, 16'd9);
    ack = 1'b0;
    op(1, 0, 1, 16'd10);
    for (int c = 0; c < 3; c++) begin
      chk("t4_wr_hold", 32'(wr), 32'h1);
      chk("t4_addr_hold", 32'(addr), 32'h0100);
      chk("t4_wdata_hold", 32'(wdata), 32'd7);
      chk("t4_busy_hold", 32'(busy), 32'h1);
      if (c == 1) op(1, 0, 1, 16'h0055);
      else tick;
    end
    chk("t4_ignored_d0", 32'(d0), 32'd10);
    ack = 1'b1;
    tick;
    chk("t4_busy_done", 32'(busy), 32'h0);
    chk("t4_wr_done", 32'(wr), 32'h0);
    chk("t4_data0", 32'(d0), 32'd10);
    chk("t4_data1", 32'(d1), 32'd9);

    // 6: reset in the middle of a fill
    ack = 1'b0;
    op(0, 1, 0, 16'd0);
    chk("t6_rd_pending", 32'(rd), 32'h1);
    chk("t6_rd_addr", 32'(addr), 32'h0100);
    #2 rst = 1'b1;
    #1;
    chk("t6_rd_drop", 32'(rd), 32'h0);
    chk("t6_busy", 32'(busy), 32'h0);
    chk("t6_data0", 32'(d0), 32'h0);
    chk("t6_data1", 32'(d1), 32'h0);
    tick;
    rst = 1'b0; ack = 1'b1;
    op(1, 0, 1, 16'd1); op(1, 0, 1, 16'd2); op(1, 0, 1, 16'd3); op(1, 0, 1, 16'd4);
    chk("t6_spill_addr", 32'(addr), 32'h0100);
    chk("t6_spill_wdata", 32'(wdata), 32'h0001);
    tick;

    // 5: single spill slot, then overflow
    op2(16'd1); op2(16'd2); op2(16'd3); op2(16'd4);
    chk("t5_spill_wr", 32'(wr2), 32'h1);
    tick;
    chk("t5_idle", 32'(busy2), 32'h0);
    chk("t5_no_ovf_yet", 32'(ovf2), 32'h0);
    op2(16'hFACE);
    chk("t5_ovf", 32'(ovf2), 32'h1);
    chk("t5_data0", 32'(d0_2), 32'hFACE);
    chk("t5_data1", 32'(d1_2), 32'd4);
    chk("t5_no_wr", 32'(wr2), 32'h0);
    chk("t5_no_busy", 32'(busy2), 32'h0);
    op2(16'h1111);
    chk("t5_ovf_sticky", 32'(ovf2), 32'h1);
    tick; tick;
    chk("t5_ovf_held", 32'(ovf2), 32'h1);
    rst2 = 1'b1;
    #1;
    chk("t5_ovf_cleared", 32'(ovf2), 32'h0);
    tick;
    rst2 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
